// File: rtl/heap_pkg.sv
// heap_pkg: shared state encoding and sizing helpers for the heap root and sorting nodes
package heap_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    function automatic int rec_width(input int width);
        return width + 1;
    endfunction

    function automatic int cap(input int depth);
        return (1 << (depth + 1)) - 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(cap(depth) + 1);
    endfunction

endpackage

// File: rtl/heap_root_node_if.sv
// heap_root_node_if: host-side record handshake into the heap root and evicted-minimum output
interface heap_root_node_if import heap_pkg::*; #(parameter int WIDTH = 15) ();

    logic                          in_valid;
    logic [rec_width(WIDTH)-1:0]   in_data;
    logic                          in_ready;
    logic                          out_valid;
    logic [rec_width(WIDTH)-1:0]   out_data;

    modport master (output in_valid, in_data, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, output in_ready, out_valid, out_data);

endinterface

// File: rtl/heap_root_node_spacing_counter.sv
// spacing_counter: loadable down-counter that stops at zero and flags it
module spacing_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = count == '0;

    // Load wins; otherwise count toward zero and hold there.
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (load) count <= load_val;
        else if (!zero) count <= count - 1'b1;

endmodule

// File: rtl/heap_root_node.sv
// heap_root_node: root slot of a pipelined min-heap; accepts records, evicts the minimum when full, paces sift-downs
module heap_root_node import heap_pkg::*; #(
    parameter int WIDTH       = 15,
    parameter int DEPTH       = 2,
    parameter int SPACING     = 5,
    parameter int INIT_CYCLES = 1 << (DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    heap_root_node_if.slave             host,
    output logic                        initialize,
    output logic                        update_out,
    output logic                        address_updated_out,
    output logic [rec_width(WIDTH)-1:0] q_U,
    output logic [rec_width(WIDTH)-1:0] aux_q_U,
    input  logic                        addr_U,
    input  logic [rec_width(WIDTH)-1:0] data_U,
    input  logic                        wren_U
);

    localparam int RW        = rec_width(WIDTH);
    localparam int CAP       = cap(DEPTH);
    localparam int OW        = occ_width(DEPTH);
    localparam int CNT_MAX   = INIT_CYCLES > SPACING ? INIT_CYCLES : SPACING;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int WAIT_LOAD = SPACING > 2 ? SPACING - 2 : 0;

    state_t          state, state_nxt;
    logic [RW-1:0]   root;
    logic [OW-1:0]   occ;
    logic            started;
    logic            wr_conflict;
    logic            cnt_load;
    logic [CW-1:0]   cnt_val;
    logic [CW-1:0]   cnt;
    logic            cnt_zero;
    logic            expiring;
    logic            accept;
    logic            unused_addr;

    spacing_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // The counter's last count is 1: leaving then makes a load of N occupy exactly N cycles.
    assign expiring            = cnt_zero || cnt == CW'(1);
    assign accept              = state == ST_IDLE && host.in_valid;
    assign initialize          = state != ST_INIT;
    assign host.in_ready       = state == ST_IDLE;
    assign update_out          = state == ST_ISSUE;
    assign address_updated_out = 1'b0;
    assign q_U                 = root;
    assign aux_q_U             = root;
    assign unused_addr         = addr_U;

    // Next-state and counter-load decode.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        case (state)
            ST_INIT: begin
                if (!started) begin
                    cnt_load = 1'b1;
                    cnt_val  = CW'(INIT_CYCLES - 1);
                end else if (expiring) state_nxt = ST_IDLE;
            end
            ST_IDLE:  if (host.in_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                cnt_load  = 1'b1;
                cnt_val   = CW'(WAIT_LOAD);
                state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (expiring) state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // State register; started marks that the INIT countdown has been loaded.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= ST_INIT;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= started | (state == ST_INIT);
        end

    // Root slot, eviction output, occupancy and the sticky write-collision flag.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            root          <= '0;
            occ           <= '0;
            host.out_valid <= 1'b0;
            host.out_data  <= '0;
            wr_conflict   <= 1'b0;
        end else if (accept) begin
            root           <= host.in_data;
            host.out_data  <= root;
            host.out_valid <= occ == OW'(CAP);
            occ            <= occ == OW'(CAP) ? occ : occ + 1'b1;
            wr_conflict    <= wr_conflict | wren_U;
        end else begin
            host.out_valid <= 1'b0;
            if (wren_U && (state == ST_IDLE || state == ST_WAIT)) root <= data_U;
        end

endmodule

// File: tb/tb_heap_root_node.sv
// tb_heap_root_node: randomized scoreboard bench with a multiset heap model and a behavioural level-1 node
module tb_heap_root_node;

    localparam int WIDTH = 15;
    localparam int DEPTH = 1;
    localparam int SPACING = 5;
    localparam int INIT_CYCLES = 4;
    localparam int CAP = 3;

    logic        clk;
    logic        rst;
    logic        initialize, update_out, address_updated_out;
    logic [15:0] q_U, aux_q_U, data_U, node_data, tst_data;
    logic        wren_U, node_wren, tst_wren;
    logic        addr_U;

    heap_root_node_if #(.WIDTH(WIDTH)) hif ();

    heap_root_node #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SPACING(SPACING), .INIT_CYCLES(INIT_CYCLES)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .host                (hif),
        .initialize          (initialize),
        .update_out          (update_out),
        .address_updated_out (address_updated_out),
        .q_U                 (q_U),
        .aux_q_U             (aux_q_U),
        .addr_U              (addr_U),
        .data_U              (data_U),
        .wren_U              (wren_U)
    );

    assign addr_U = 1'b0;
    assign wren_U = node_wren | tst_wren;
    assign data_U = tst_wren ? tst_data : node_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int unsigned mset[$];
    int m_occ;
    logic [15:0] exp_q[$];
    logic tight;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Heap of CAP slots starts as all zeros; each push evicts the minimum and inserts the new record.
    task automatic model_reset();
        mset.delete();
        for (int i = 0; i < CAP; i++) mset.push_back(0);
        m_occ = 0;
    endtask

    function automatic int unsigned model_min();
        int unsigned m = mset[0];
        foreach (mset[i]) if (mset[i] < m) m = mset[i];
        return m;
    endfunction

    task automatic model_push(input int unsigned v);
        int idx = 0;
        foreach (mset[i]) if (mset[i] < mset[idx]) idx = i;
        if (m_occ == CAP) exp_q.push_back(16'(mset[idx]));
        else m_occ++;
        mset.delete(idx);
        mset.push_back(v);
    endtask

    // Behavioural level-1 node: two leaves, one compare-swap with the root per update pulse.
    initial begin
        logic [15:0] leaf[2];
        int k;
        node_wren = 1'b0;
        node_data = '0;
        leaf[0] = '0;
        leaf[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            node_wren = 1'b0;
            if (!initialize) begin
                leaf[0] = '0;
                leaf[1] = '0;
            end else if (update_out) begin
                k = leaf[0] <= leaf[1] ? 0 : 1;
                if (leaf[k] < q_U) begin
                    node_data = leaf[k];
                    leaf[k] = q_U;
                    @(posedge clk);
                    #1;
                    node_wren = 1'b1;
                end
            end
        end
    end

    // Monitor: scoreboard pops on out_valid; sift pulse legality and spacing.
    initial begin
        int cyc = 0;
        int last_upd = -1;
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (hif.out_valid) begin
                if (exp_q.size() == 0) check("out_valid_unexpected", hif.out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    check("out_data", hif.out_data, e);
                end
            end
            if (!tight) last_upd = -1;
            if (update_out) begin
                check("update_while_uninit", initialize, 1);
                check("addr_updated_out", address_updated_out, 0);
                if (last_upd >= 0) check("update_spacing", cyc - last_upd, SPACING);
                last_upd = cyc;
            end
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_initialize"}, initialize, 0);
        check({tag, "_in_ready"}, hif.in_ready, 0);
        check({tag, "_out_valid"}, hif.out_valid, 0);
        check({tag, "_out_data"}, hif.out_data, 0);
        check({tag, "_update_out"}, update_out, 0);
        check({tag, "_q_U"}, q_U, 0);
        check({tag, "_occ"}, dut.occ, 0);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!initialize && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("init_cycles", n, INIT_CYCLES);
        check("ready_after_init", hif.in_ready, 1);
        @(posedge clk);
        #1;
        check("ready_next_cycle", hif.in_ready, 1);
    endtask

    // mode 0: plain push; 1: level-1 write collides with the accept; 2: write in WAIT then reset mid-WAIT.
    task automatic push(input logic [15:0] v, input int mode);
        int n = 0;
        hif.in_valid = 1'b1;
        hif.in_data = v;
        while (!hif.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!hif.in_ready) begin
            check("accept_timeout", hif.in_ready, 1);
            return;
        end
        model_push(v);
        if (mode == 1) begin
            tst_wren = 1'b1;
            tst_data = 16'd4;
        end
        @(posedge clk);
        #1;
        tst_wren = 1'b0;
        if (mode == 1) begin
            check("collide_root_host_wins", q_U, v);
            check("collide_err_flag", dut.wr_conflict, 1);
        end
        if (mode == 2) begin
            hif.in_valid = 1'b0;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            tst_wren = 1'b1;
            tst_data = 16'd4;
            @(posedge clk);
            #1;
            tst_wren = 1'b0;
            check("wait_write_root", q_U, 4);
            check("wait_write_aux", aux_q_U, 4);
            #2 rst = 1'b0;
            #1 reset_checks("midwait");
            return;
        end
        n = 0;
        while (!hif.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sift_done_ready", hif.in_ready, 1);
        check("root_after_sift", q_U, model_min());
        check("aux_eq_root", aux_q_U, q_U);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        hif.in_valid = 1'b0;
        hif.in_data = '0;
        tst_wren = 1'b0;
        tst_data = '0;
        tight = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        check("por_err_flag", dut.wr_conflict, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_init();

        tight = 1'b1;
        push(16'd7, 0);
        push(16'd3, 0);
        push(16'd5, 0);
        push(16'd9, 0);
        push(16'd1, 0);
        hif.in_valid = 1'b0;
        tight = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        tight = 1'b1;
        repeat (20) push(16'($urandom_range(0, 65535)), 0);
        hif.in_valid = 1'b0;
        tight = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        push(16'd8, 1);
        hif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(16'd11, 2);
        hif.in_valid = 1'b0;
        check("pending_at_reset", exp_q.size(), 0);
        exp_q.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("held");
        @(negedge clk);
        rst = 1'b1;
        wait_init();

        tight = 1'b1;
        repeat (5) push(16'($urandom_range(1, 65535)), 0);
        hif.in_valid = 1'b0;
        tight = 1'b0;
        check("occ_refilled", dut.occ, CAP);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
